// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch request at a time, returns the
// addressed 32-bit word after LATENCY cycles and holds it until the fetch side accepts.
module imem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  localparam int unsigned IDXW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [63:0]     req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [63:0]     resp_addr,
  output logic            resp_err,
  input  logic            load_en,
  input  logic [IDXW-1:0] load_idx,
  input  logic [31:0]     load_data,
  output logic            busy
);

  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [64:0] LIMIT = 65'(BASE_ADDR) + 65'(4 * DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [63:0]     r_addr;
  logic            w_accept;
  logic            w_capture;
  logic            w_enter_resp;
  logic [63:0]     w_look_addr;
  logic [63:0]     w_off;
  logic            w_err;
  logic [IDXW-1:0] w_idx;
  logic [31:0]     r_mem [DEPTH];

  // A new request may be taken in IDLE, or in RESP on the same edge as the handshake
  assign req_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE, S_RESP: begin
        if ((r_state == S_RESP) && resp_ready) begin
          w_next = S_IDLE;
        end
        if (w_accept) begin
          w_capture = 1'b1;
          if (LATENCY == 1) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With LATENCY==1 the lookup uses the address being accepted this edge
  assign w_look_addr = w_capture ? req_addr : r_addr;
  assign w_off       = w_look_addr - BASE_ADDR;
  assign w_idx       = IDXW'(w_off >> 2);
  assign w_err       = (w_look_addr[1:0] != 2'b00) || (w_look_addr < BASE_ADDR) ||
                       ({1'b0, w_look_addr} >= LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr <= req_addr;
      end
      resp_valid <= (w_next == S_RESP);
      busy       <= (w_next != S_IDLE);
      if (w_enter_resp) begin
        resp_data <= w_err ? 32'h0000_0000 : r_mem[w_idx];
        resp_err  <= w_err;
        resp_addr <= w_look_addr;
      end
    end
  end

  // Word array is not reset; a load on the read edge is seen only by later reads
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized
// requests checked against an array-based reference of the address/latency rules.
`timescale 1ns/1ps
module tb_imem_responder;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IDXW  = 10;
  localparam int unsigned LAT   = 2;
  localparam int unsigned LAT4  = 4;

  logic            clk = 1'b0;
  logic            rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en, busy;
  logic [63:0]     req_addr, resp_addr;
  logic [31:0]     resp_data, load_data;
  logic [IDXW-1:0] load_idx;

  logic            b_rst, b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic            b_load_en, b_busy;
  logic [63:0]     b_req_addr, b_resp_addr;
  logic [31:0]     b_resp_data, b_load_data;
  logic [IDXW-1:0] b_load_idx;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];

  imem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_addr(resp_addr), .resp_err(resp_err), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data), .busy(busy)
  );

  imem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT4)) u_dut4 (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_addr(b_req_addr), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_addr(b_resp_addr), .resp_err(b_resp_err),
    .load_en(b_load_en), .load_idx(b_load_idx), .load_data(b_load_data), .busy(b_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: word address must be aligned and inside [BASE, BASE + 4*DEPTH)
  function automatic void ref_lookup(input logic [63:0] a, output logic [31:0] d,
                                     output logic e);
    if ((a % 64'd4) != 64'd0 || a < BASE || (a - BASE) >= 64'(4 * DEPTH)) begin
      e = 1'b1;
      d = 32'h0;
    end else begin
      e = 1'b0;
      d = model[int'((a - BASE) / 64'd4)];
    end
  endfunction

  task automatic load_word(input int idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = IDXW'(idx);
    load_data = data;
    tick();
    load_en = 1'b0;
    model[idx] = data;
  endtask

  // One request from IDLE, optional backpressure for 'stall' cycles, then handshake
  task automatic do_req(input logic [63:0] a, input int stall);
    logic [31:0] ed;
    logic        ee;
    int          n;
    ref_lookup(a, ed, ee);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = (stall == 0);
    #1 chk_b("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    n = 1;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk_w("latency", 32'(n), 32'(LAT));
    chk_w("resp_data", resp_data, ed);
    chk_b("resp_err", resp_err, ee);
    chk_a("resp_addr", resp_addr, a);
    chk_b("busy_resp", busy, 1'b1);
    for (int s = 0; s < stall; s++) begin
      chk_b("bp_req_ready", req_ready, 1'b0);
      tick();
      chk_b("bp_valid", resp_valid, 1'b1);
      chk_w("bp_data", resp_data, ed);
      chk_a("bp_addr", resp_addr, a);
    end
    resp_ready = 1'b1;
    #1 chk_b("req_ready_resp", req_ready, 1'b1);
    tick();
    chk_b("post_valid", resp_valid, 1'b0);
    chk_b("post_busy", busy, 1'b0);
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] old_w;
    int          n;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    load_en = 1'b0; load_idx = '0; load_data = '0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b0;
    b_load_en = 1'b0; b_load_idx = '0; b_load_data = '0;
    tick();
    tick();
    chk_b("rst_req_ready", req_ready, 1'b1);
    chk_b("rst_resp_valid", resp_valid, 1'b0);
    chk_w("rst_resp_data", resp_data, 32'h0);
    chk_a("rst_resp_addr", resp_addr, 64'h0);
    chk_b("rst_resp_err", resp_err, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    rst = 1'b0;
    b_rst = 1'b0;
    tick();

    for (int i = 0; i < int'(DEPTH); i++) load_word(i, $urandom);
    load_word(0, 32'h0000_0413);
    load_word(1, 32'h0010_0073);
    load_word(2, 32'hDEAD_BEEF);
    load_word(3, 32'h1234_5678);

    do_req(BASE + 64'h4, 0);

    // Back-to-back: second request accepted on the first response's handshake edge
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
    tick();
    req_addr = BASE + 64'h8;
    tick();
    chk_b("b2b_valid0", resp_valid, 1'b1);
    chk_w("b2b_data0", resp_data, 32'h0000_0413);
    #1 chk_b("b2b_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk_b("b2b_gap_valid", resp_valid, 1'b0);
    chk_b("b2b_gap_busy", busy, 1'b1);
    tick();
    chk_b("b2b_valid1", resp_valid, 1'b1);
    chk_w("b2b_data1", resp_data, 32'hDEAD_BEEF);
    chk_a("b2b_addr1", resp_addr, BASE + 64'h8);
    tick();
    chk_b("b2b_done", resp_valid, 1'b0);

    do_req(BASE + 64'h8, 5);

    do_req(64'h0000_0000_8000_0002, 0);
    do_req(64'h0000_0000_7FFF_FFFC, 1);
    do_req(64'h0000_0000_8000_1000, 0);
    do_req(BASE + 64'(4 * (DEPTH - 1)), 0);

    // Load landing on the RESP-entry edge is not seen by that read
    old_w = model[3];
    req_valid = 1'b1; req_addr = BASE + 64'hC; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    load_en = 1'b1; load_idx = IDXW'(3); load_data = 32'hCAFE_F00D;
    tick();
    load_en = 1'b0;
    model[3] = 32'hCAFE_F00D;
    chk_b("race_valid", resp_valid, 1'b1);
    chk_w("race_old", resp_data, old_w);
    tick();
    do_req(BASE + 64'hC, 0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
        3:       a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
        4:       a = BASE - 64'(4 * $urandom_range(1, 1000));
        default: a = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 1000));
      endcase
      if ($urandom_range(0, 1) == 1) load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
      do_req(a, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset during WAIT on the LATENCY=4 instance
    b_load_en = 1'b1; b_load_idx = IDXW'(5); b_load_data = 32'hA5A5_0F0F;
    tick();
    b_load_en = 1'b0;
    b_req_valid = 1'b1; b_req_addr = BASE + 64'd20; b_resp_ready = 1'b1;
    tick();
    b_req_valid = 1'b0;
    tick();
    chk_b("l4_busy_wait", b_busy, 1'b1);
    chk_b("l4_valid_wait", b_resp_valid, 1'b0);
    b_rst = 1'b1;
    #1;
    chk_b("l4_rst_valid", b_resp_valid, 1'b0);
    chk_b("l4_rst_busy", b_busy, 1'b0);
    chk_b("l4_rst_req_ready", b_req_ready, 1'b1);
    tick();
    b_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_b("l4_discarded", b_resp_valid, 1'b0);
    end
    b_req_valid = 1'b1; b_req_addr = BASE + 64'd20;
    tick();
    b_req_valid = 1'b0;
    n = 1;
    while (!b_resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk_w("l4_latency", 32'(n), 32'(LAT4));
    chk_w("l4_data", b_resp_data, 32'hA5A5_0F0F);
    chk_b("l4_err", b_resp_err, 1'b0);
    tick();
    chk_b("l4_done", b_resp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
